ltssm_detect_polling: RTL and testbench
=======================================

# ltssm_detect_polling

LTSSM front-end sequencer covering Detect.Quiet, Detect.Active and Polling.Active, then handing off in Polling.Configuration. It drives `substate`, `ElecIdle_req` and `Detect_req` into PIPE_Control and consumes that block's one-cycle `Detect_status` pulse. It also gates the TS1 ordered-set generator and counts TS1/TS2 reception.

## Interface
- `number_of_lanes`, 4: lane count; sets the `RxElecIdle` width.
- `QUIET_TIMEOUT`, 3000000: Detect.Quiet timeout in pclk cycles (12 ms at 250 MHz).
- `ACTIVE_TIMEOUT`, 3000000: Detect.Active timeout in pclk cycles.
- `POLL_TIMEOUT`, 6000000: Polling.Active timeout in pclk cycles (24 ms).
- `TX_TS1_MIN`, 1024: TS1 count that must be sent before exiting Polling.Active.
- `RX_TS_MIN`, 8: consecutive good TS1/TS2 count that must be received.

Ports:
- `pclk` in 1: the block's single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `link_down` in 1: forces a return to Detect.Quiet.
- `RxElecIdle` in `number_of_lanes`: per-lane electrical-idle indication from the PHY (1 = idle).
- `Detect_status` in 1: receiver-detected pulse from PIPE_Control.
- `ts1_sent` in 1: one-cycle pulse per TS1 transmitted.
- `ts_rx_valid` in 1: one-cycle pulse per TS1/TS2 received.
- `ts_rx_ok` in 1: qualifies `ts_rx_valid`; 1 means the set is good (compliance bit clear, PAD link/lane).
- `substate` out 5: LTSSM substate to PIPE_Control.
- `ElecIdle_req` out 1: requests transmitter electrical idle.
- `Detect_req` out 1: requests a receiver-detect operation.
- `send_ts1` out 1: enables the TS1 generator.
- `polling_done` out 1: one-cycle pulse on entry to Polling.Configuration.

## Operation
- State encoding on `substate`: DetectQuiet=0, DetectActive=1, PollingActive=2, PollingConfigration=3. No other values are driven.
- All outputs are registered. Reset values: `substate`=0, `ElecIdle_req`=1, `Detect_req`=0, `send_ts1`=0, `polling_done`=0. All counters are 0.
- `timer` is 23 bits. It clears on every state change and otherwise increments, saturating at all ones.
- **DetectQuiet**:
  - `ElecIdle_req`=1.
  - Exits to DetectActive when `timer`==QUIET_TIMEOUT-1, or when any `RxElecIdle` bit is 0.
- **DetectActive**:
  - `ElecIdle_req`=1.
  - `Detect_req`=1 only on the first cycle of the state.
  - `Detect_status`=1 → PollingActive.
  - `timer`==ACTIVE_TIMEOUT-1 with no detect → DetectQuiet.
- **PollingActive**:
  - `ElecIdle_req`=0 and `send_ts1`=1.
  - `tx_cnt` (11 bits) increments on `ts1_sent` and saturates at TX_TS1_MIN.
  - `rx_cnt` (4 bits) increments on `ts_rx_valid`&`ts_rx_ok` and saturates at RX_TS_MIN. It clears to 0 on `ts_rx_valid`&!`ts_rx_ok`.
  - Both counters clear on entry to PollingActive.
  - Exits to PollingConfigration when `tx_cnt`==TX_TS1_MIN and `rx_cnt`==RX_TS_MIN. This check uses the registered counts, so an exit can occur on the cycle after the final pulse.
  - `timer`==POLL_TIMEOUT-1 → DetectQuiet.
- **PollingConfigration**:
  - `ElecIdle_req`=0 and `send_ts1`=0.
  - `polling_done`=1 on the entry cycle only.
  - Holds until `link_down`.

Priority when events coincide:
- `link_down` beats everything: it forces DetectQuiet on the next edge from any state. If already in DetectQuiet, it restarts `timer`.
- In PollingActive, a same-cycle completion and timeout resolve to completion.
- In DetectActive, a same-cycle `Detect_status` and timeout resolve to PollingActive.
- `Detect_status` outside DetectActive is ignored.
- `ts1_sent` and `ts_rx_valid` outside PollingActive are ignored.

Reset asserted mid-operation returns all outputs and counters to their reset values immediately. This is asynchronous and does not wait for a clock edge.

## Timing
- State-change latency is 1 pclk from the sampled condition. `substate` and the related outputs update on the same edge.
- `Detect_req` is a single-cycle pulse, coincident with the first cycle of `substate`==1. PIPE_Control holds TxDetectRx itself, so the pulse is not extended.
- `polling_done` is coincident with the first cycle of `substate`==3.
- `send_ts1` falls on the same edge that `substate` leaves 2.

## Configuration
- `DETECT_RETRY_EN` defined:
  - On the first Detect.Active timeout, the block stays in DetectActive, clears `timer` and pulses `Detect_req` again.
  - Only the second timeout goes to DetectQuiet.
  - A 1-bit retry flag clears on entry to DetectActive from any other state.
- `DETECT_RETRY_EN` undefined:
  - The first timeout goes to DetectQuiet.
  - The retry flag is not present.

## Test plan
Bench parameters: QUIET_TIMEOUT=20, ACTIVE_TIMEOUT=30, POLL_TIMEOUT=200, TX_TS1_MIN=16, RX_TS_MIN=8.

- **Reset and quiet timeout.** Release reset with `RxElecIdle`=4'hF → `substate` is 0 for 20 cycles, then 1. `Detect_req` is high for exactly 1 cycle and `ElecIdle_req` stays 1.
- **Idle exit during quiet.** Drive `RxElecIdle`=4'hE at cycle 5 of DetectQuiet → `substate`=1 on the next edge.
- **Detect success.** Pulse `Detect_status` at cycle 3 of DetectActive → `substate`=2, `send_ts1`=1 and `ElecIdle_req`=0 on the next edge.
- **Detect failure.** No `Detect_status` → after 30 cycles `substate`=0.
  - With `DETECT_RETRY_EN`: after 30 cycles a second `Detect_req` pulse is seen; after 60 cycles `substate`=0.
- **Polling completion and bad-set reset.** Send 16 `ts1_sent` pulses plus 5 good receives, 1 bad receive, then 8 good receives.
  - Exit occurs only after the 8th good receive following the bad one.
  - On exit, `substate`=3 and `polling_done` pulses once.
- **Polling timeout and link_down.** With no receives, `substate` returns to 0 after 200 cycles. Asserting `link_down` while in state 3 → `substate`=0 on the next edge and `ElecIdle_req`=1.

Source files
------------

// File: rtl/ltssm_detect_polling_if.sv
// ltssm_detect_polling_if
//   Groups the LTSSM front-end sequencer's PHY/PIPE-side signals.
//   modport slave  : the sequencer (consumes PHY/PIPE status, drives requests)
//   modport master : the environment (PHY, PIPE_Control, TS1 generator/receiver)
//   Signals:
//     link_down      forces a return to Detect.Quiet
//     RxElecIdle     per-lane electrical idle (1 = idle)
//     Detect_status  one-cycle receiver-detected pulse
//     ts1_sent       one-cycle pulse per TS1 transmitted
//     ts_rx_valid    one-cycle pulse per TS1/TS2 received
//     ts_rx_ok       qualifies ts_rx_valid (1 = good set)
//     substate       LTSSM substate to PIPE_Control
//     ElecIdle_req   transmitter electrical-idle request
//     Detect_req     receiver-detect request pulse
//     send_ts1       TS1 generator enable
//     polling_done   pulse on entry to Polling.Configuration
interface ltssm_detect_polling_if #(
  parameter int number_of_lanes = 4
);
  logic                       link_down;
  logic [number_of_lanes-1:0] RxElecIdle;
  logic                       Detect_status;
  logic                       ts1_sent;
  logic                       ts_rx_valid;
  logic                       ts_rx_ok;
  logic [4:0]                 substate;
  logic                       ElecIdle_req;
  logic                       Detect_req;
  logic                       send_ts1;
  logic                       polling_done;

  modport slave (
    input  link_down, RxElecIdle, Detect_status, ts1_sent, ts_rx_valid, ts_rx_ok,
    output substate, ElecIdle_req, Detect_req, send_ts1, polling_done
  );

  modport master (
    output link_down, RxElecIdle, Detect_status, ts1_sent, ts_rx_valid, ts_rx_ok,
    input  substate, ElecIdle_req, Detect_req, send_ts1, polling_done
  );
endinterface

// File: rtl/ltssm_detect_polling.sv
// ltssm_detect_polling
//   LTSSM front-end sequencer: Detect.Quiet -> Detect.Active -> Polling.Active
//   -> Polling.Configuration (hand-off). Drives substate/ElecIdle_req/Detect_req
//   towards PIPE_Control, gates the TS1 generator and counts TS1/TS2 reception.
//   All outputs are registered.
// Ports:
//   pclk     single clock
//   reset_n  asynchronous active-low reset
//   bus      ltssm_detect_polling_if.slave (see interface header for signals)
// Optional feature:
//   DETECT_RETRY_EN  when defined, the first Detect.Active timeout re-issues
//                    Detect_req and stays in Detect.Active; only the second
//                    timeout returns to Detect.Quiet.
module ltssm_detect_polling #(
  parameter int number_of_lanes = 4,
  parameter int QUIET_TIMEOUT   = 3000000,
  parameter int ACTIVE_TIMEOUT  = 3000000,
  parameter int POLL_TIMEOUT    = 6000000,
  parameter int TX_TS1_MIN      = 1024,
  parameter int RX_TS_MIN       = 8
) (
  input  logic                  pclk,
  input  logic                  reset_n,
  ltssm_detect_polling_if.slave bus
);

  typedef enum logic [4:0] {
    DETECT_QUIET   = 5'd0,
    DETECT_ACTIVE  = 5'd1,
    POLLING_ACTIVE = 5'd2,
    POLLING_CONFIG = 5'd3
  } state_e;

  localparam logic [22:0] QUIET_LAST  = 23'(QUIET_TIMEOUT - 1);
  localparam logic [22:0] ACTIVE_LAST = 23'(ACTIVE_TIMEOUT - 1);
  localparam logic [22:0] POLL_LAST   = 23'(POLL_TIMEOUT - 1);
  localparam logic [10:0] TX_MAX      = 11'(TX_TS1_MIN);
  localparam logic [3:0]  RX_MAX      = 4'(RX_TS_MIN);
  localparam logic [number_of_lanes-1:0] ALL_IDLE = '1;

  state_e      state_q;
  logic [22:0] timer_q;
  logic [22:0] timer_d;
  logic [10:0] tx_cnt_q;
  logic [3:0]  rx_cnt_q;
  logic        elec_idle_q;
  logic        detect_req_q;
  logic        send_ts1_q;
  logic        polling_done_q;
`ifdef DETECT_RETRY_EN
  logic        retry_q;
`endif

  // Saturating increment; any state change overrides this with zero.
  assign timer_d = (&timer_q) ? timer_q : timer_q + 23'd1;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= DETECT_QUIET;
      timer_q        <= '0;
      tx_cnt_q       <= '0;
      rx_cnt_q       <= '0;
      elec_idle_q    <= 1'b1;
      detect_req_q   <= 1'b0;
      send_ts1_q     <= 1'b0;
      polling_done_q <= 1'b0;
`ifdef DETECT_RETRY_EN
      retry_q        <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; set only on the cycle that enters a state.
      detect_req_q   <= 1'b0;
      polling_done_q <= 1'b0;
      timer_q        <= timer_d;
      if (bus.link_down) begin
        // Also restarts the quiet timer when already in Detect.Quiet.
        state_q     <= DETECT_QUIET;
        timer_q     <= '0;
        elec_idle_q <= 1'b1;
        send_ts1_q  <= 1'b0;
      end else begin
        case (state_q)
          DETECT_QUIET: begin
            if (timer_q == QUIET_LAST || bus.RxElecIdle != ALL_IDLE) begin
              state_q      <= DETECT_ACTIVE;
              timer_q      <= '0;
              detect_req_q <= 1'b1;
`ifdef DETECT_RETRY_EN
              retry_q      <= 1'b0;
`endif
            end
          end
          DETECT_ACTIVE: begin
            // Detect wins over a coincident timeout.
            if (bus.Detect_status) begin
              state_q     <= POLLING_ACTIVE;
              timer_q     <= '0;
              elec_idle_q <= 1'b0;
              send_ts1_q  <= 1'b1;
              tx_cnt_q    <= '0;
              rx_cnt_q    <= '0;
            end else if (timer_q == ACTIVE_LAST) begin
`ifdef DETECT_RETRY_EN
              if (!retry_q) begin
                retry_q      <= 1'b1;
                timer_q      <= '0;
                detect_req_q <= 1'b1;
              end else begin
                state_q <= DETECT_QUIET;
                timer_q <= '0;
              end
`else
              state_q <= DETECT_QUIET;
              timer_q <= '0;
`endif
            end
          end
          POLLING_ACTIVE: begin
            if (bus.ts1_sent && tx_cnt_q != TX_MAX) tx_cnt_q <= tx_cnt_q + 11'd1;
            if (bus.ts_rx_valid) begin
              if (!bus.ts_rx_ok)          rx_cnt_q <= '0;
              else if (rx_cnt_q != RX_MAX) rx_cnt_q <= rx_cnt_q + 4'd1;
            end
            // Uses registered counts: completion beats a coincident timeout.
            if (tx_cnt_q == TX_MAX && rx_cnt_q == RX_MAX) begin
              state_q        <= POLLING_CONFIG;
              timer_q        <= '0;
              send_ts1_q     <= 1'b0;
              polling_done_q <= 1'b1;
            end else if (timer_q == POLL_LAST) begin
              state_q     <= DETECT_QUIET;
              timer_q     <= '0;
              elec_idle_q <= 1'b1;
              send_ts1_q  <= 1'b0;
            end
          end
          POLLING_CONFIG: begin
            // Holds until link_down.
          end
          default: begin
            state_q     <= DETECT_QUIET;
            timer_q     <= '0;
            elec_idle_q <= 1'b1;
            send_ts1_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.substate     = state_q;
  assign bus.ElecIdle_req = elec_idle_q;
  assign bus.Detect_req   = detect_req_q;
  assign bus.send_ts1     = send_ts1_q;
  assign bus.polling_done = polling_done_q;

endmodule

// File: tb/tb_ltssm_detect_polling.sv
module tb_ltssm_detect_polling;

  localparam int Q_TO = 20;
  localparam int A_TO = 30;
  localparam int P_TO = 200;
  localparam int TX_N = 16;
  localparam int RX_N = 8;

`ifdef DETECT_RETRY_EN
  localparam int  EXP_DA_LEN = 2 * A_TO;
  localparam int  EXP_DREQ   = 2;
  localparam int  EXP_SECOND = A_TO;
  localparam bit  RETRY      = 1'b1;
`else
  localparam int  EXP_DA_LEN = A_TO;
  localparam int  EXP_DREQ   = 1;
  localparam int  EXP_SECOND = -1;
  localparam bit  RETRY      = 1'b0;
`endif

  logic pclk;
  logic reset_n;
  int   tests;
  int   failed;

  ltssm_detect_polling_if #(.number_of_lanes(4)) bus ();

  ltssm_detect_polling #(
    .number_of_lanes(4),
    .QUIET_TIMEOUT  (Q_TO),
    .ACTIVE_TIMEOUT (A_TO),
    .POLL_TIMEOUT   (P_TO),
    .TX_TS1_MIN     (TX_N),
    .RX_TS_MIN      (RX_N)
  ) dut (
    .pclk   (pclk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Reference model: substate number, cycles spent in it, TS counts.
  typedef struct {
    int st;
    int age;
    int tx;
    int rx;
    bit retry;
    bit entry;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t model_next(mdl_t c, bit ld, logic [3:0] idle, bit ds,
                                      bit ts1, bit v, bit ok);
    mdl_t n;
    int   nxt;
    bit   restart;
    n       = c;
    nxt     = c.st;
    restart = 1'b0;
    if (ld) begin
      nxt     = 0;
      restart = 1'b1;
    end else if (c.st == 0) begin
      if (c.age == Q_TO - 1 || idle != 4'hF) nxt = 1;
    end else if (c.st == 1) begin
      if (ds) nxt = 2;
      else if (c.age == A_TO - 1) begin
        if (RETRY && !c.retry) begin
          n.retry = 1'b1;
          restart = 1'b1;
        end else nxt = 0;
      end
    end else if (c.st == 2) begin
      if (c.tx == TX_N && c.rx == RX_N) nxt = 3;
      else if (c.age == P_TO - 1) nxt = 0;
      if (ts1) n.tx = (c.tx + 1 > TX_N) ? TX_N : c.tx + 1;
      if (v) n.rx = ok ? ((c.rx + 1 > RX_N) ? RX_N : c.rx + 1) : 0;
    end
    if (nxt != c.st || restart) begin
      n.entry = 1'b1;
      n.age   = 0;
      if (nxt == 2) begin
        n.tx = 0;
        n.rx = 0;
      end
      if (nxt == 1 && c.st != 1) n.retry = 1'b0;
    end else begin
      n.entry = 1'b0;
      n.age   = c.age + 1;
    end
    n.st = nxt;
    return n;
  endfunction

  always @(posedge pclk or negedge reset_n) begin
    if (!reset_n) m <= '{st: 0, age: 0, tx: 0, rx: 0, retry: 1'b0, entry: 1'b1};
    else m <= model_next(m, bus.link_down, bus.RxElecIdle, bus.Detect_status,
                         bus.ts1_sent, bus.ts_rx_valid, bus.ts_rx_ok);
  end

  task automatic idle_inputs();
    bus.link_down     = 1'b0;
    bus.RxElecIdle    = 4'hF;
    bus.Detect_status = 1'b0;
    bus.ts1_sent      = 1'b0;
    bus.ts_rx_valid   = 1'b0;
    bus.ts_rx_ok      = 1'b0;
  endtask

  // Leave quiet via an idle exit, then detect; ends on the first PollingActive sample.
  task automatic go_polling();
    bus.RxElecIdle = 4'hE;
    @(negedge pclk);
    bus.RxElecIdle    = 4'hF;
    bus.Detect_status = 1'b1;
    @(negedge pclk);
    bus.Detect_status = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    int dreq;
    bit eidle_ok;
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) @(negedge pclk);
    tests++;
    if ({bus.substate, bus.ElecIdle_req, bus.Detect_req, bus.send_ts1, bus.polling_done}
        !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failed++;
      $display("FAIL reset_values: got %b required %b",
               {bus.substate, bus.ElecIdle_req, bus.Detect_req, bus.send_ts1, bus.polling_done},
               {5'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    end
    reset_n  = 1'b1;
    n        = 0;
    eidle_ok = 1'b1;
    while (bus.substate == 5'd0 && n < 100) begin
      if (bus.ElecIdle_req !== 1'b1 || bus.Detect_req !== 1'b0) eidle_ok = 1'b0;
      n++;
      @(negedge pclk);
    end
    tests++;
    if (n != Q_TO) begin
      failed++;
      $display("FAIL quiet_len: got %0d cycles required %0d", n, Q_TO);
    end
    tests++;
    if (bus.substate !== 5'd1) begin
      failed++;
      $display("FAIL quiet_exit_state: got %0d required 1", bus.substate);
    end
    dreq = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.Detect_req === 1'b1) dreq++;
      if (bus.ElecIdle_req !== 1'b1) eidle_ok = 1'b0;
      @(negedge pclk);
    end
    tests++;
    if (dreq != 1) begin
      failed++;
      $display("FAIL detect_req_pulse: got %0d high cycles required 1", dreq);
    end
    tests++;
    if (eidle_ok !== 1'b1) begin
      failed++;
      $display("FAIL elecidle_detect: got %0d required 1", eidle_ok);
    end
  endtask

  task automatic test_idle_exit();
    bus.link_down = 1'b1;
    @(negedge pclk);
    bus.link_down = 1'b0;
    repeat (5) @(negedge pclk);
    tests++;
    if (bus.substate !== 5'd0) begin
      failed++;
      $display("FAIL idle_exit_pre: got %0d required 0", bus.substate);
    end
    bus.RxElecIdle = 4'hE;
    @(negedge pclk);
    bus.RxElecIdle = 4'hF;
    tests++;
    if ({bus.substate, bus.Detect_req} !== {5'd1, 1'b1}) begin
      failed++;
      $display("FAIL idle_exit: got state %0d dreq %0d required 1 1",
               bus.substate, bus.Detect_req);
    end
  endtask

  task automatic test_detect_success();
    repeat (3) @(negedge pclk);
    bus.Detect_status = 1'b1;
    @(negedge pclk);
    bus.Detect_status = 1'b0;
    tests++;
    if ({bus.substate, bus.send_ts1, bus.ElecIdle_req} !== {5'd2, 1'b1, 1'b0}) begin
      failed++;
      $display("FAIL detect_success: got state %0d send %0d eidle %0d required 2 1 0",
               bus.substate, bus.send_ts1, bus.ElecIdle_req);
    end
  endtask

  task automatic test_polling_done();
    bit early;
    early = 1'b0;
    for (int i = 0; i < TX_N; i++) begin
      bus.ts1_sent    = 1'b1;
      bus.ts_rx_valid = (i < 5);
      bus.ts_rx_ok    = 1'b1;
      @(negedge pclk);
      if (bus.substate !== 5'd2) early = 1'b1;
    end
    bus.ts1_sent    = 1'b0;
    bus.ts_rx_valid = 1'b1;
    bus.ts_rx_ok    = 1'b0;
    @(negedge pclk);
    if (bus.substate !== 5'd2) early = 1'b1;
    for (int k = 1; k <= RX_N; k++) begin
      bus.ts_rx_valid = 1'b1;
      bus.ts_rx_ok    = 1'b1;
      @(negedge pclk);
      if (bus.substate !== 5'd2) early = 1'b1;
      bus.ts_rx_valid = 1'b0;
      if (k < RX_N) begin
        @(negedge pclk);
        if (bus.substate !== 5'd2) early = 1'b1;
      end
    end
    tests++;
    if (early !== 1'b0) begin
      failed++;
      $display("FAIL polling_early_exit: got %0d required 0", early);
    end
    @(negedge pclk);
    tests++;
    if ({bus.substate, bus.polling_done} !== {5'd3, 1'b1}) begin
      failed++;
      $display("FAIL polling_exit: got state %0d done %0d required 3 1",
               bus.substate, bus.polling_done);
    end
    @(negedge pclk);
    tests++;
    if ({bus.substate, bus.polling_done, bus.send_ts1, bus.ElecIdle_req}
        !== {5'd3, 1'b0, 1'b0, 1'b0}) begin
      failed++;
      $display("FAIL polling_config_hold: got %b required %b",
               {bus.substate, bus.polling_done, bus.send_ts1, bus.ElecIdle_req},
               {5'd3, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_link_down();
    repeat (3) @(negedge pclk);
    bus.link_down = 1'b1;
    @(negedge pclk);
    bus.link_down = 1'b0;
    tests++;
    if ({bus.substate, bus.ElecIdle_req, bus.send_ts1} !== {5'd0, 1'b1, 1'b0}) begin
      failed++;
      $display("FAIL link_down: got state %0d eidle %0d send %0d required 0 1 0",
               bus.substate, bus.ElecIdle_req, bus.send_ts1);
    end
  endtask

  task automatic test_detect_fail();
    int n;
    int pulses;
    int second_at;
    bus.RxElecIdle = 4'hE;
    @(negedge pclk);
    bus.RxElecIdle = 4'hF;
    n         = 0;
    pulses    = 0;
    second_at = -1;
    while (bus.substate == 5'd1 && n < 200) begin
      if (bus.Detect_req === 1'b1) begin
        pulses++;
        if (pulses == 2) second_at = n;
      end
      n++;
      @(negedge pclk);
    end
    tests++;
    if (n != EXP_DA_LEN || bus.substate !== 5'd0) begin
      failed++;
      $display("FAIL detect_fail_len: got %0d cycles state %0d required %0d cycles state 0",
               n, bus.substate, EXP_DA_LEN);
    end
    tests++;
    if (pulses != EXP_DREQ || second_at != EXP_SECOND) begin
      failed++;
      $display("FAIL detect_fail_pulses: got %0d pulses second at %0d required %0d at %0d",
               pulses, second_at, EXP_DREQ, EXP_SECOND);
    end
  endtask

  task automatic test_poll_timeout();
    int n;
    go_polling();
    n = 0;
    while (bus.substate == 5'd2 && n < 500) begin
      bus.ts1_sent = 1'($urandom_range(0, 1));
      n++;
      @(negedge pclk);
    end
    bus.ts1_sent = 1'b0;
    tests++;
    if (n != P_TO || bus.substate !== 5'd0 || bus.ElecIdle_req !== 1'b1) begin
      failed++;
      $display("FAIL poll_timeout: got %0d cycles state %0d required %0d cycles state 0",
               n, bus.substate, P_TO);
    end
  endtask

  task automatic test_async_reset();
    go_polling();
    repeat (3) @(negedge pclk);
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({bus.substate, bus.ElecIdle_req, bus.Detect_req, bus.send_ts1, bus.polling_done}
        !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failed++;
      $display("FAIL async_reset: got %b required %b",
               {bus.substate, bus.ElecIdle_req, bus.Detect_req, bus.send_ts1, bus.polling_done},
               {5'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    end
    @(negedge pclk);
    reset_n = 1'b1;
  endtask

  task automatic test_random(int cycles);
    logic [8:0] got;
    logic [8:0] exp;
    int         shown;
    shown = 0;
    for (int i = 0; i < cycles; i++) begin
      bus.link_down     = ($urandom_range(0, 299) == 0);
      bus.RxElecIdle    = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      bus.Detect_status = ($urandom_range(0, 9) == 0);
      bus.ts1_sent      = 1'($urandom_range(0, 1));
      bus.ts_rx_valid   = ($urandom_range(0, 2) == 0);
      bus.ts_rx_ok      = ($urandom_range(0, 11) != 0);
      @(negedge pclk);
      exp = {5'(m.st), (m.st < 2), (m.st == 1 && m.entry), (m.st == 2), (m.st == 3 && m.entry)};
      got = {bus.substate, bus.ElecIdle_req, bus.Detect_req, bus.send_ts1, bus.polling_done};
      tests++;
      if (got !== exp) begin
        failed++;
        if (shown < 20) begin
          shown++;
          $display("FAIL random_cycle_%0d: got %b required %b", i, got, exp);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_idle_exit();
    test_detect_success();
    test_polling_done();
    test_link_down();
    test_detect_fail();
    test_poll_timeout();
    test_async_reset();
    test_random(4000);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
